// File: rtl/intc_pkg.sv
// Interrupt controller shared types: source trigger modes, register map
// byte offsets and the claim priority encoder.
package intc_pkg;

  typedef enum logic [1:0] {
    LEVEL  = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2,
    CHANGE = 2'd3
  } intc_mode_e;

  localparam logic [4:0] OFF_ENABLE  = 5'h00;
  localparam logic [4:0] OFF_PENDING = 5'h04;
  localparam logic [4:0] OFF_MODE    = 5'h08;
  localparam logic [4:0] OFF_SWSET   = 5'h0C;
  localparam logic [4:0] OFF_CLAIM   = 5'h10;
  localparam logic [4:0] OFF_RAW     = 5'h14;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [3:0] first_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int unsigned i = 16; i > 0; i--) begin
      if (v[i-1]) idx = 4'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 classic bus bundle, 32-bit address and data.
interface wishbone_b3;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  modport slave  (input adr, dat_i, we, sel, stb, cyc, output dat_o, ack, err);
  modport master (output adr, dat_i, we, sel, stb, cyc, input dat_o, ack, err);
endinterface

// File: rtl/intc_detect.sv
// Per-source trigger detection: sample history, edge events and the
// pending flag with set-over-clear priority.
module intc_detect
  import intc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample,
  input  intc_mode_e mode,
  input  logic       set,
  input  logic       clr,
  output logic       pending
);

  logic hist;
  logic lvl_q;
  logic edge_q;
  logic evt;

  // Edge event from current sample against previous sample.
  always_comb begin
    evt = 1'b0;
    case (mode)
      RISE:    evt = sample & ~hist;
      FALL:    evt = ~sample & hist;
      CHANGE:  evt = sample ^ hist;
      default: evt = 1'b0;
    endcase
  end

  // History always tracks the sample (also in reset, so release is quiet).
  // Level and edge state live in separate flops so that leaving LEVEL mode
  // never carries a stale level into the latched edge flag.
  always_ff @(posedge clk) begin
    hist <= sample;
    if (rst) begin
      lvl_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      lvl_q <= sample;
      if (mode == LEVEL)    edge_q <= 1'b0;
      else if (evt || set)  edge_q <= 1'b1;
      else if (clr)         edge_q <= 1'b0;
    end
  end

  assign pending = (mode == LEVEL) ? lvl_q : edge_q;

endmodule

// File: rtl/wb_intc.sv
// Wishbone interrupt controller: enable/pending/mode/swset/claim/raw
// registers, per-source detectors and a registered irq.
// Optional WB_INTC_SYNC_EN: 2-flop synchronizer on src before detection.
module wb_intc
  import intc_pkg::*;
#(
  parameter int unsigned N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  wishbone_b3.slave        bus,
  input  logic [N_SRC-1:0] src,
  output logic             irq
);

  logic [N_SRC-1:0]   sample;
  logic [N_SRC-1:0]   enable;
  logic [N_SRC-1:0]   pending;
  logic [N_SRC-1:0]   w1c;
  logic [N_SRC-1:0]   swset;
  logic [N_SRC-1:0]   claim_clr;
  logic [2*N_SRC-1:0] mode;
  logic [15:0]        pend_en;
  logic [15:0]        claim16;
  logic [3:0]         claim_idx;
  logic               claim_any;
  logic [31:0]        rdata;
  logic [31:0]        dat_q;
  logic               ack_q;
  logic               access;
  logic               wr;
  logic               rd;
  logic [2:0]         reg_sel;
  logic               unused_bits;

  assign access  = bus.stb & bus.cyc & ~ack_q;
  assign wr      = access & bus.we;
  assign rd      = access & ~bus.we;
  assign reg_sel = bus.adr[4:2];
  assign unused_bits = ^{bus.sel, bus.adr[31:5], bus.adr[1:0], bus.dat_i};

`ifdef WB_INTC_SYNC_EN
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;

  // Two-stage synchronizer for asynchronous sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign sample = sync2;
`else
  assign sample = src;
`endif

  // Claim target: lowest-index enabled pending source.
  always_comb begin
    pend_en = '0;
    pend_en[N_SRC-1:0] = pending & enable;
    claim_any = |pend_en;
    claim_idx = first_set(pend_en);
    claim16 = '0;
    if (rd && reg_sel == OFF_CLAIM[4:2] && claim_any) claim16[claim_idx] = 1'b1;
    claim_clr = claim16[N_SRC-1:0];
  end

  // Write-strobe decode for the W1C and W1S registers.
  always_comb begin
    w1c   = '0;
    swset = '0;
    if (wr && reg_sel == OFF_PENDING[4:2]) w1c   = bus.dat_i[N_SRC-1:0];
    if (wr && reg_sel == OFF_SWSET[4:2])   swset = bus.dat_i[N_SRC-1:0];
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    intc_detect u_det (
      .clk     (clk),
      .rst     (rst),
      .sample  (sample[i]),
      .mode    (intc_mode_e'(mode[2*i +: 2])),
      .set     (swset[i]),
      .clr     (w1c[i] | claim_clr[i]),
      .pending (pending[i])
    );
  end

  // Read-data mux; unmapped offsets and bits above N_SRC read zero.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      OFF_ENABLE[4:2]:  rdata[N_SRC-1:0]   = enable;
      OFF_PENDING[4:2]: rdata[N_SRC-1:0]   = pending;
      OFF_MODE[4:2]:    rdata[2*N_SRC-1:0] = mode;
      OFF_CLAIM[4:2]:   rdata = {claim_any, 27'd0, claim_idx};
      OFF_RAW[4:2]:     rdata[N_SRC-1:0]   = sample;
      default:          rdata = '0;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= '0;
      mode   <= '0;
    end else if (wr) begin
      if (reg_sel == OFF_ENABLE[4:2]) enable <= bus.dat_i[N_SRC-1:0];
      if (reg_sel == OFF_MODE[4:2])   mode   <= bus.dat_i[2*N_SRC-1:0];
    end
  end

  // Bus response: single-cycle ack, never two in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= access;
      if (rd) dat_q <= rdata;
    end
  end

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(pending & enable);
  end

  assign bus.ack   = ack_q;
  assign bus.dat_o = dat_q;
  assign bus.err   = 1'b0;

endmodule

// File: tb/tb_wb_intc.sv
// Self-checking bench for wb_intc (N_SRC = 8).
module tb_wb_intc;

`ifdef WB_INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic [7:0]  src;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] exp;

  wishbone_b3 wb();

  wb_intc #(.N_SRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb),
    .src (src),
    .irq (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=time limit required=finish");
    $fatal(1, "watchdog");
  end

  // All bus tasks start and end at a negedge.
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic got;
    got = 1'b0;
    wb.adr = a; wb.dat_i = d; wb.we = 1'b1; wb.sel = 4'hF; wb.stb = 1'b1; wb.cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = wb.ack;
    end
    wb.stb = 1'b0; wb.cyc = 1'b0; wb.we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_write_ack adr=%h got=none required=ack", a);
    end
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = 'x;
    wb.adr = a; wb.we = 1'b0; wb.sel = 4'hF; wb.stb = 1'b1; wb.cyc = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = wb.ack;
      if (got) d = wb.dat_o;
    end
    wb.stb = 1'b0; wb.cyc = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst = 1'b1; src = s;
    wb.stb = 1'b0; wb.cyc = 1'b0; wb.we = 1'b0; wb.adr = '0; wb.dat_i = '0; wb.sel = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (wb.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb.ack); end
    checks++; if (wb.dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat_o got=%h exp=0", wb.dat_o); end
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(32'h0);
      wb_read(32'(r * 4), rd);
      exp = exp_q.pop_front();
      checks++;
      if (rd !== exp) begin errors++; $display("FAIL reset_reg%0d got=%h exp=%h", r, rd, exp); end
    end
    // Access overlapped by reset must not be acknowledged.
    wb.adr = '0; wb.we = 1'b0; wb.stb = 1'b1; wb.cyc = 1'b1; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (wb.ack !== 1'b0) begin errors++; $display("FAIL reset_abandon got=%b exp=0", wb.ack); end
    end
    wb.stb = 1'b0; wb.cyc = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rise();
    do_reset(8'h00);
    wb_write(32'h08, 32'h1);
    wb_write(32'h00, 32'h1);
    src[0] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_early got=%b exp=0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got=%b exp=1", irq); end
    exp_q.push_back(32'h1);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL rise_pending got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_level();
    do_reset(8'h05);
    wb_write(32'h00, 32'h05);
    repeat (LAT + 1) @(negedge clk);
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h0000_0005);
    wb_read(32'h10, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL level_claim got=%h exp=%h", rd, exp); end
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL level_pending got=%h exp=%h", rd, exp); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_irq_on got=%b exp=1", irq); end
    src = 8'h00;
    repeat (LAT + 1) @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL level_irq_hold got=%b exp=1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL level_irq_off got=%b exp=0", irq); end
  endtask

  task automatic test_w1c_vs_event();
    do_reset(8'h00);
    wb_write(32'h08, 32'hFFFF);
    src[3] = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    // Toggle lands on the same edge that accepts the W1C.
    src[3] = 1'b0;
    repeat (LAT) @(negedge clk);
    wb_write(32'h04, 32'h08);
    exp_q.push_back(32'h08);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL set_over_clr got=%h exp=%h", rd, exp); end
    wb_write(32'h04, 32'h08);
    exp_q.push_back(32'h00);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL w1c_plain got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_swset_claim();
    do_reset(8'h00);
    wb_write(32'h08, 32'h55);
    wb_write(32'h0C, 32'h0C);
    wb_write(32'h00, 32'h08);
    exp_q.push_back(32'h8000_0003);
    exp_q.push_back(32'h0000_0004);
    exp_q.push_back(32'h0000_0000);
    wb_read(32'h10, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL claim_value got=%h exp=%h", rd, exp); end
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL claim_cleared got=%h exp=%h", rd, exp); end
    wb_read(32'h0C, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL swset_reads0 got=%h exp=%h", rd, exp); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL claim_irq_off got=%b exp=0", irq); end
    wb_write(32'h00, 32'h04);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL enable_irq_early got=%b exp=0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL enable_irq got=%b exp=1", irq); end
  endtask

  task automatic test_reset_held();
    do_reset(8'hFF);
    repeat (LAT + 2) @(negedge clk);
    exp_q.push_back(32'hFF);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL held_level got=%h exp=%h", rd, exp); end
    wb_write(32'h08, 32'h5555);
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h00);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL held_rise got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_fall();
    do_reset(8'h02);
    wb_write(32'h08, 32'h08);
    src[1] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    exp_q.push_back(32'h02);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL fall_pending got=%h exp=%h", rd, exp); end
    wb_write(32'h04, 32'h02);
    exp_q.push_back(32'h00);
    wb_read(32'h04, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL fall_w1c got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_regs();
    do_reset(8'hA5);
    repeat (LAT + 1) @(negedge clk);
    exp_q.push_back(32'hA5);
    wb_read(32'h14, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL raw got=%h exp=%h", rd, exp); end
    wb_write(32'h00, 32'hFFFF_FFFF);
    wb_write(32'h08, 32'hFFFF_FFFF);
    wb_write(32'h18, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'hFFFF);
    exp_q.push_back(32'h0);
    wb_read(32'h00, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL enable_width got=%h exp=%h", rd, exp); end
    wb_read(32'h08, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL mode_width got=%h exp=%h", rd, exp); end
    wb_read(32'h18, rd);
    exp = exp_q.pop_front();
    checks++; if (rd !== exp) begin errors++; $display("FAIL unmapped got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    do_reset(8'h00);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    wb.adr = 32'h00; wb.we = 1'b0; wb.stb = 1'b1; wb.cyc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({31'd0, wb.ack} !== exp) begin
        errors++;
        $display("FAIL b2b_ack%0d got=%b exp=%0d", i, wb.ack, exp);
      end
    end
    wb.stb = 1'b0; wb.cyc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; src = '0;
    wb.adr = '0; wb.dat_i = '0; wb.we = 1'b0; wb.sel = 4'hF; wb.stb = 1'b0; wb.cyc = 1'b0;
    @(negedge clk);
    test_reset();
    test_rise();
    test_level();
    test_w1c_vs_event();
    test_swset_claim();
    test_reset_held();
    test_fall();
    test_regs();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
